// File: rtl/ahb_mem_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter. It shares one single-port memory
// between the core's instruction (imem) and data (dmem) ports.
// Each upstream request is captured into a hold register, and the master is
// stalled with hready until the arbiter serves it. Downstream transfers are
// issued one at a time and are never pipelined.
// dmem has priority. A consecutive-grant counter gives imem a turn after
// DMEM_MAX_CONSEC dmem grants that were issued while imem was waiting.
//
// state | meaning
// IDLE  | no transfer downstream, waiting for a pending request
// ADDR  | downstream address phase, mem_htrans = NONSEQ
// DATA  | downstream data phase for the current owner
module ahb_mem_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int DMEM_MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [1:0]    imem_htrans,
    input  logic [AW-1:0] imem_haddr,
    input  logic          imem_hwrite,
    input  logic [2:0]    imem_hsize,
    input  logic [DW-1:0] imem_hwdata,
    output logic [DW-1:0] imem_hrdata,
    output logic          imem_hready,
    output logic          imem_hresp,
    input  logic [1:0]    dmem_htrans,
    input  logic [AW-1:0] dmem_haddr,
    input  logic          dmem_hwrite,
    input  logic [2:0]    dmem_hsize,
    input  logic [DW-1:0] dmem_hwdata,
    output logic [DW-1:0] dmem_hrdata,
    output logic          dmem_hready,
    output logic          dmem_hresp,
    output logic [1:0]    mem_htrans,
    output logic [AW-1:0] mem_haddr,
    output logic          mem_hwrite,
    output logic [2:0]    mem_hsize,
    output logic [DW-1:0] mem_hwdata,
    input  logic [DW-1:0] mem_hrdata,
    input  logic          mem_hready,
    input  logic          mem_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [3:0] CONSEC_MAX    = 4'(DMEM_MAX_CONSEC);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [3:0]    consec_q, consec_d;

    logic          pend_i_q, pend_i_d;
    logic [AW-1:0] hold_i_addr_q, hold_i_addr_d;
    logic          hold_i_write_q, hold_i_write_d;
    logic [2:0]    hold_i_size_q, hold_i_size_d;

    logic          pend_d_q, pend_d_d;
    logic [AW-1:0] hold_d_addr_q, hold_d_addr_d;
    logic          hold_d_write_q, hold_d_write_d;
    logic [2:0]    hold_d_size_q, hold_d_size_d;

    logic [1:0]    mem_htrans_q, mem_htrans_d;
    logic [AW-1:0] mem_haddr_q, mem_haddr_d;
    logic          mem_hwrite_q, mem_hwrite_d;
    logic [2:0]    mem_hsize_q, mem_hsize_d;

    logic          done_i, done_d;
    logic          cap_i, cap_d;
    logic          arb_en;
    logic          grant_i;

    // Completion of the owner's data phase releases that upstream port.
    assign done_i = (state_q == ST_DATA) && (owner_q == OWN_I) && mem_hready;
    assign done_d = (state_q == ST_DATA) && (owner_q == OWN_D) && mem_hready;

    assign imem_hready = !pend_i_q || done_i;
    assign dmem_hready = !pend_d_q || done_d;

    // SEQ is accepted like NONSEQ because every transfer is re-issued as NONSEQ.
    assign cap_i = imem_hready && ((imem_htrans == HTRANS_NONSEQ) || (imem_htrans == HTRANS_SEQ));
    assign cap_d = dmem_hready && ((dmem_htrans == HTRANS_NONSEQ) || (dmem_htrans == HTRANS_SEQ));

    assign imem_hrdata = (owner_q == OWN_I) ? mem_hrdata : '0;
    assign dmem_hrdata = (owner_q == OWN_D) ? mem_hrdata : '0;
    assign imem_hresp  = (state_q == ST_DATA) && (owner_q == OWN_I) && mem_hresp;
    assign dmem_hresp  = (state_q == ST_DATA) && (owner_q == OWN_D) && mem_hresp;

    assign mem_htrans = mem_htrans_q;
    assign mem_haddr  = mem_haddr_q;
    assign mem_hwrite = mem_hwrite_q;
    assign mem_hsize  = mem_hsize_q;

    // Write data comes straight from the stalled owner during the data phase.
    always_comb begin
        mem_hwdata = '0;
        if (state_q == ST_DATA) begin
            if (owner_q == OWN_I)
                mem_hwdata = imem_hwdata;
            else if (owner_q == OWN_D)
                mem_hwdata = dmem_hwdata;
        end
    end

    // Request capture: a new capture wins over the clear from a completing transfer.
    always_comb begin
        pend_i_d       = pend_i_q;
        hold_i_addr_d  = hold_i_addr_q;
        hold_i_write_d = hold_i_write_q;
        hold_i_size_d  = hold_i_size_q;
        pend_d_d       = pend_d_q;
        hold_d_addr_d  = hold_d_addr_q;
        hold_d_write_d = hold_d_write_q;
        hold_d_size_d  = hold_d_size_q;
        if (cap_i) begin
            pend_i_d       = 1'b1;
            hold_i_addr_d  = imem_haddr;
            hold_i_write_d = imem_hwrite;
            hold_i_size_d  = imem_hsize;
        end else if (done_i) begin
            pend_i_d = 1'b0;
        end
        if (cap_d) begin
            pend_d_d       = 1'b1;
            hold_d_addr_d  = dmem_haddr;
            hold_d_write_d = dmem_hwrite;
            hold_d_size_d  = dmem_hsize;
        end else if (done_d) begin
            pend_d_d = 1'b0;
        end
    end

    // Next-state, arbitration and registered downstream address phase.
    // Arbitration uses the post-capture pending view, so a request captured at
    // this edge can be granted at the same edge.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        consec_d     = consec_q;
        mem_htrans_d = mem_htrans_q;
        mem_haddr_d  = mem_haddr_q;
        mem_hwrite_d = mem_hwrite_q;
        mem_hsize_d  = mem_hsize_q;
        arb_en       = 1'b0;
        grant_i      = 1'b0;

        case (state_q)
            ST_IDLE: arb_en = 1'b1;
            ST_ADDR: begin
                if (mem_hready) begin
                    state_d      = ST_DATA;
                    mem_htrans_d = HTRANS_IDLE;
                end
            end
            ST_DATA: arb_en = mem_hready;
            default: state_d = ST_IDLE;
        endcase

        if (pend_i_d && pend_d_d)
            grant_i = (consec_q == CONSEC_MAX);
        else
            grant_i = pend_i_d;

        if (arb_en) begin
            if (pend_i_d || pend_d_d) begin
                state_d      = ST_ADDR;
                mem_htrans_d = HTRANS_NONSEQ;
                if (grant_i) begin
                    owner_d      = OWN_I;
                    mem_haddr_d  = hold_i_addr_d;
                    mem_hwrite_d = hold_i_write_d;
                    mem_hsize_d  = hold_i_size_d;
                    consec_d     = 4'd0;
                end else begin
                    owner_d      = OWN_D;
                    mem_haddr_d  = hold_d_addr_d;
                    mem_hwrite_d = hold_d_write_d;
                    mem_hsize_d  = hold_d_size_d;
                    if (pend_i_d && (consec_q != 4'hF))
                        consec_d = consec_q + 4'd1;
                end
            end else begin
                state_d      = ST_IDLE;
                owner_d      = OWN_NONE;
                mem_htrans_d = HTRANS_IDLE;
            end
        end
    end

    // State, hold and output registers; reset drops any held requests.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_NONE;
            consec_q       <= 4'd0;
            pend_i_q       <= 1'b0;
            hold_i_addr_q  <= '0;
            hold_i_write_q <= 1'b0;
            hold_i_size_q  <= 3'd0;
            pend_d_q       <= 1'b0;
            hold_d_addr_q  <= '0;
            hold_d_write_q <= 1'b0;
            hold_d_size_q  <= 3'd0;
            mem_htrans_q   <= HTRANS_IDLE;
            mem_haddr_q    <= '0;
            mem_hwrite_q   <= 1'b0;
            mem_hsize_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            consec_q       <= consec_d;
            pend_i_q       <= pend_i_d;
            hold_i_addr_q  <= hold_i_addr_d;
            hold_i_write_q <= hold_i_write_d;
            hold_i_size_q  <= hold_i_size_d;
            pend_d_q       <= pend_d_d;
            hold_d_addr_q  <= hold_d_addr_d;
            hold_d_write_q <= hold_d_write_d;
            hold_d_size_q  <= hold_d_size_d;
            mem_htrans_q   <= mem_htrans_d;
            mem_haddr_q    <= mem_haddr_d;
            mem_hwrite_q   <= mem_hwrite_d;
            mem_hsize_q    <= mem_hsize_d;
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter. Inputs change 1 ns after each rising
// edge, and outputs are sampled on the falling edge.
module tb_ahb_mem_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic        clk;
    logic        resetn;
    logic [1:0]  imem_htrans;
    logic [31:0] imem_haddr;
    logic        imem_hwrite;
    logic [2:0]  imem_hsize;
    logic [31:0] imem_hwdata;
    logic [31:0] imem_hrdata;
    logic        imem_hready;
    logic        imem_hresp;
    logic [1:0]  dmem_htrans;
    logic [31:0] dmem_haddr;
    logic        dmem_hwrite;
    logic [2:0]  dmem_hsize;
    logic [31:0] dmem_hwdata;
    logic [31:0] dmem_hrdata;
    logic        dmem_hready;
    logic        dmem_hresp;
    logic [1:0]  mem_htrans;
    logic [31:0] mem_haddr;
    logic        mem_hwrite;
    logic [2:0]  mem_hsize;
    logic [31:0] mem_hwdata;
    logic [31:0] mem_hrdata;
    logic        mem_hready;
    logic        mem_hresp;

    int tests_run    = 0;
    int tests_failed = 0;

    ahb_mem_arbiter #(.AW(32), .DW(32), .DMEM_MAX_CONSEC(4)) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_htrans (imem_htrans),
        .imem_haddr  (imem_haddr),
        .imem_hwrite (imem_hwrite),
        .imem_hsize  (imem_hsize),
        .imem_hwdata (imem_hwdata),
        .imem_hrdata (imem_hrdata),
        .imem_hready (imem_hready),
        .imem_hresp  (imem_hresp),
        .dmem_htrans (dmem_htrans),
        .dmem_haddr  (dmem_haddr),
        .dmem_hwrite (dmem_hwrite),
        .dmem_hsize  (dmem_hsize),
        .dmem_hwdata (dmem_hwdata),
        .dmem_hrdata (dmem_hrdata),
        .dmem_hready (dmem_hready),
        .dmem_hresp  (dmem_hresp),
        .mem_htrans  (mem_htrans),
        .mem_haddr   (mem_haddr),
        .mem_hwrite  (mem_hwrite),
        .mem_hsize   (mem_hsize),
        .mem_hwdata  (mem_hwdata),
        .mem_hrdata  (mem_hrdata),
        .mem_hready  (mem_hready),
        .mem_hresp   (mem_hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_htrans = T_IDLE;
        dmem_htrans = T_IDLE;
        imem_hwrite = 1'b0;
        dmem_hwrite = 1'b0;
        mem_hready  = 1'b1;
        mem_hresp   = 1'b0;
    endtask

    // Expected downstream address in each odd cycle of the starvation run.
    logic [31:0] starve_addr [0:12];

    initial begin
        starve_addr = '{32'h0, 32'h1000, 32'h0, 32'h1004, 32'h0, 32'h1008, 32'h0,
                        32'h100C, 32'h0, 32'h40, 32'h0, 32'h1010, 32'h0};
        resetn      = 1'b0;
        imem_htrans = T_IDLE;
        imem_haddr  = '0;
        imem_hwrite = 1'b0;
        imem_hsize  = 3'd2;
        imem_hwdata = '0;
        dmem_htrans = T_IDLE;
        dmem_haddr  = '0;
        dmem_hwrite = 1'b0;
        dmem_hsize  = 3'd2;
        dmem_hwdata = '0;
        mem_hrdata  = 32'hAAAA5555;
        mem_hready  = 1'b1;
        mem_hresp   = 1'b0;

        // Reset values
        #1;
        check("rst_htrans", {30'd0, mem_htrans}, 32'd0);
        check("rst_haddr", mem_haddr, 32'd0);
        check("rst_i_hready", {31'd0, imem_hready}, 32'd1);
        check("rst_d_hready", {31'd0, dmem_hready}, 32'd1);
        check("rst_i_hrdata", imem_hrdata, 32'd0);
        check("rst_d_hrdata", dmem_hrdata, 32'd0);
        check("rst_i_hresp", {31'd0, imem_hresp}, 32'd0);
        check("rst_hwdata", mem_hwdata, 32'd0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Single imem read
        imem_htrans = T_NONSEQ; imem_haddr = 32'h100;
        @(negedge clk);
        check("t1_c0_i_hready", {31'd0, imem_hready}, 32'd1);
        next_cycle();
        imem_htrans = T_IDLE;
        @(negedge clk);
        check("t1_c1_htrans", {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
        check("t1_c1_haddr", mem_haddr, 32'h100);
        check("t1_c1_i_hready", {31'd0, imem_hready}, 32'd0);
        next_cycle();
        mem_hrdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_c2_i_hready", {31'd0, imem_hready}, 32'd1);
        check("t1_c2_i_hrdata", imem_hrdata, 32'hDEADBEEF);
        check("t1_c2_htrans", {30'd0, mem_htrans}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t1_c3_htrans", {30'd0, mem_htrans}, 32'd0);
        next_cycle();

        // Simultaneous imem read and dmem write: dmem first
        imem_htrans = T_NONSEQ; imem_haddr = 32'h0;
        dmem_htrans = T_NONSEQ; dmem_haddr = 32'h2000_0000; dmem_hwrite = 1'b1;
        next_cycle();
        idle_inputs();
        dmem_hwdata = 32'd123456789;
        @(negedge clk);
        check("t2_c1_htrans", {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
        check("t2_c1_haddr", mem_haddr, 32'h2000_0000);
        check("t2_c1_hwrite", {31'd0, mem_hwrite}, 32'd1);
        check("t2_c1_i_hready", {31'd0, imem_hready}, 32'd0);
        check("t2_c1_d_hready", {31'd0, dmem_hready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t2_c2_hwdata", mem_hwdata, 32'd123456789);
        check("t2_c2_d_hready", {31'd0, dmem_hready}, 32'd1);
        check("t2_c2_i_hready", {31'd0, imem_hready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t2_c3_htrans", {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
        check("t2_c3_haddr", mem_haddr, 32'h0);
        check("t2_c3_hwrite", {31'd0, mem_hwrite}, 32'd0);
        check("t2_c3_i_hready", {31'd0, imem_hready}, 32'd0);
        check("t2_c3_hwdata", mem_hwdata, 32'd0);
        next_cycle();
        mem_hrdata = 32'h55;
        @(negedge clk);
        check("t2_c4_i_hready", {31'd0, imem_hready}, 32'd1);
        check("t2_c4_i_hrdata", imem_hrdata, 32'h55);
        check("t2_c4_d_hrdata", dmem_hrdata, 32'h0);
        next_cycle();
        next_cycle();

        // dmem streaming while imem waits: 4 dmem grants, then imem, then dmem
        begin
            logic [31:0] d_addr;
            d_addr = 32'h1000;
            for (int c = 0; c <= 12; c++) begin
                imem_htrans = (c == 0) ? T_NONSEQ : T_IDLE;
                imem_haddr  = 32'h40;
                dmem_htrans = (c <= 11) ? T_NONSEQ : T_IDLE;
                dmem_haddr  = d_addr;
                dmem_hwrite = 1'b0;
                @(negedge clk);
                if (c >= 1) begin
                    if ((c % 2) == 1) begin
                        check($sformatf("t3_c%0d_htrans", c), {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
                        check($sformatf("t3_c%0d_haddr", c), mem_haddr, starve_addr[c]);
                    end else begin
                        check($sformatf("t3_c%0d_htrans", c), {30'd0, mem_htrans}, 32'd0);
                    end
                end
                check($sformatf("t3_c%0d_i_hready", c), {31'd0, imem_hready},
                      (c == 0 || c >= 10) ? 32'd1 : 32'd0);
                if (dmem_hready) d_addr = d_addr + 32'd4;
                next_cycle();
            end
        end
        idle_inputs();
        next_cycle();

        // Downstream wait states on a dmem read, imem pending behind it
        dmem_htrans = T_NONSEQ; dmem_haddr = 32'h300;
        next_cycle();
        dmem_htrans = T_IDLE;
        imem_htrans = T_NONSEQ; imem_haddr = 32'h80;
        @(negedge clk);
        check("t4_c1_haddr", mem_haddr, 32'h300);
        next_cycle();
        imem_htrans = T_IDLE;
        mem_hready  = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("t4_c%0d_d_hready", c), {31'd0, dmem_hready}, 32'd0);
            check($sformatf("t4_c%0d_i_hready", c), {31'd0, imem_hready}, 32'd0);
            check($sformatf("t4_c%0d_haddr", c), mem_haddr, 32'h300);
            next_cycle();
        end
        mem_hready = 1'b1;
        mem_hrdata = 32'hCAFE0001;
        @(negedge clk);
        check("t4_c5_d_hready", {31'd0, dmem_hready}, 32'd1);
        check("t4_c5_d_hrdata", dmem_hrdata, 32'hCAFE0001);
        check("t4_c5_i_hready", {31'd0, imem_hready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t4_c6_htrans", {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
        check("t4_c6_haddr", mem_haddr, 32'h80);
        next_cycle();
        @(negedge clk);
        check("t4_c7_i_hready", {31'd0, imem_hready}, 32'd1);
        next_cycle();
        next_cycle();

        // Two-cycle ERROR response on an imem transfer
        imem_htrans = T_NONSEQ; imem_haddr = 32'h200;
        next_cycle();
        imem_htrans = T_IDLE;
        next_cycle();
        mem_hready = 1'b0; mem_hresp = 1'b1;
        @(negedge clk);
        check("t5_c2_i_hresp", {31'd0, imem_hresp}, 32'd1);
        check("t5_c2_i_hready", {31'd0, imem_hready}, 32'd0);
        check("t5_c2_d_hresp", {31'd0, dmem_hresp}, 32'd0);
        next_cycle();
        mem_hready = 1'b1; mem_hresp = 1'b1;
        @(negedge clk);
        check("t5_c3_i_hresp", {31'd0, imem_hresp}, 32'd1);
        check("t5_c3_i_hready", {31'd0, imem_hready}, 32'd1);
        check("t5_c3_d_hresp", {31'd0, dmem_hresp}, 32'd0);
        next_cycle();
        mem_hresp = 1'b0;
        @(negedge clk);
        check("t5_c4_i_hresp", {31'd0, imem_hresp}, 32'd0);
        next_cycle();

        // Reset during ADDR with both ports pending
        imem_htrans = T_NONSEQ; imem_haddr = 32'h500;
        dmem_htrans = T_NONSEQ; dmem_haddr = 32'h600;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t6_pre_htrans", {30'd0, mem_htrans}, {30'd0, T_NONSEQ});
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_htrans", {30'd0, mem_htrans}, 32'd0);
        check("t6_rst_haddr", mem_haddr, 32'd0);
        check("t6_rst_i_hready", {31'd0, imem_hready}, 32'd1);
        check("t6_rst_d_hready", {31'd0, dmem_hready}, 32'd1);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t6_post%0d_htrans", c), {30'd0, mem_htrans}, 32'd0);
            check($sformatf("t6_post%0d_i_hready", c), {31'd0, imem_hready}, 32'd1);
            check($sformatf("t6_post%0d_d_hready", c), {31'd0, dmem_hready}, 32'd1);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ahb_mem_arbiter.md
Name: ahb_mem_arbiter

Overview:
- Shares one single-port AHB-Lite memory slave between the core's instruction (imem) and data (dmem) AHB-Lite master ports.
- Sits between the core's imem and dmem buses and the memory model or SRAM controller.
- Each upstream port looks like a slave: requests are captured, held and stalled with hready until served.
- Downstream transfers are issued one at a time, never pipelined: dmem has priority, bounded by an anti-starvation counter for imem.

Parameters:
- AW, 32, address width
- DW, 32, data width
- DMEM_MAX_CONSEC, 4, max consecutive dmem grants while imem waits (range 1..15)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- imem_htrans  in  2  imem transfer type
- imem_haddr  in  AW  imem address
- imem_hwrite  in  1  imem write
- imem_hsize  in  3  imem size
- imem_hwdata  in  DW  imem write data
- imem_hrdata  out  DW  imem read data
- imem_hready  out  1  imem ready
- imem_hresp  out  1  imem response
- dmem_htrans, dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hwdata, dmem_hrdata, dmem_hready, dmem_hresp: same directions and widths as the imem ports, for dmem
- mem_htrans  out  2  downstream transfer type
- mem_haddr  out  AW  downstream address
- mem_hwrite  out  1  downstream write
- mem_hsize  out  3  downstream size
- mem_hwdata  out  DW  downstream write data
- mem_hrdata  in  DW  downstream read data
- mem_hready  in  1  downstream ready
- mem_hresp  in  1  downstream response

Behaviour:
- Reset (async, resetn=0), all registers clear:
  - pending flags 0; FSM IDLE; consec counter 0
  - mem_htrans=IDLE(00), mem_haddr=0, mem_hwrite=0, mem_hsize=0
  - imem_hready=dmem_hready=1; hresp=0; hrdata=0
  - Reset mid-transfer silently drops held requests.
- Capture (per port x):
  - At posedge, if x_hready=1 and x_htrans[1]=1 (NONSEQ, or SEQ treated as NONSEQ), latch haddr, hwrite and hsize into a hold register and set pend_x=1.
  - BUSY and IDLE are ignored.
- Upstream ready (combinational): x_hready = !pend_x | (state==DATA & owner==x & mem_hready).
- Upstream read data and response:
  - x_hrdata = mem_hrdata when owner==x, else 0.
  - x_hresp = mem_hresp when state==DATA & owner==x, else 0.
  - hresp is passed straight through, including both cycles of a two-cycle ERROR.
- FSM states IDLE, ADDR, DATA:
  - IDLE: if any pend_x, grant and move to ADDR; drive mem_htrans=NONSEQ plus the owner's held addr/write/size (registered outputs).
  - ADDR: at posedge with mem_hready=1, go to DATA and set mem_htrans=IDLE.
  - DATA: mem_hwdata = owner's x_hwdata (combinational, stable because the upstream is stalled). At posedge with mem_hready=1: clear pend_owner, unless a new request is captured at the same edge, in which case pend stays 1 with the new fields. Then re-arbitrate: go to ADDR if any pending, else IDLE.
- Grant rules:
  - Only dmem pending: grant dmem.
  - Only imem pending: grant imem.
  - Both pending: grant imem if consec==DMEM_MAX_CONSEC, else grant dmem.
  - consec increments on a dmem grant while pend_i=1 (saturating), and clears on any imem grant.
- Latency: upstream address phase at cycle 0 gives downstream address phase at cycle 1 and upstream completion at cycle 2 (one wait state) with zero downstream waits. A losing port adds 2+N cycles per transfer ahead of it, where N is the downstream wait states.
- Simultaneous capture on both ports at the same edge: both become pending, and arbitration follows the rules above.
- mem_hwdata=0 when not in DATA.

Test Plan:
- Single imem read, addr 0x100, mem returns 0xDEADBEEF with 0 waits -> mem_htrans NONSEQ in cycle 1, imem_hready=0 in cycle 1 and 1 in cycle 2 with imem_hrdata=0xDEADBEEF.
- Simultaneous imem read 0x0 and dmem write 0x2000_0000 data 123456789 -> dmem served first, mem_hwdata=123456789 in its DATA cycle; imem completes 2 cycles later.
- dmem issues back-to-back requests continuously while imem waits, DMEM_MAX_CONSEC=4 -> exactly 4 dmem grants, then 1 imem grant, then dmem resumes; imem_hready stays low throughout the wait.
- mem_hready held low 3 cycles in DATA of a dmem read -> dmem_hready low for those cycles, imem stays stalled if pending, mem_haddr stable.
- mem_hresp=1 for 2 cycles on an imem transfer -> imem_hresp mirrors it, dmem_hresp=0.
- resetn asserted during ADDR with both ports pending -> immediate mem_htrans=00, both hready=1, no transfer is issued after resetn deasserts.
